// File: rtl/err_countdown_pkg.sv
// Shared definitions for the error countdown block: error codes, digit and
// seconds widths, valid countdown bounds and the controller state type.
package err_countdown_pkg;

   localparam int ERR_W = 4;
   localparam int BCD_W = 4;
   localparam int SEC_W = 7;

   // Error code 0 means "no error"; any other code is reported by the compute path.
   localparam logic [ERR_W-1:0] ERR_NONE = 4'd0;

   // Range of countdown lengths accepted from the settings menu.
   localparam logic [SEC_W-1:0] ERR_CD_MIN_SEC = 7'd1;
   localparam logic [SEC_W-1:0] ERR_CD_MAX_SEC = 7'd99;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational binary-to-BCD converter for values 0..99 (two digits).
module bin2bcd_99
   import err_countdown_pkg::*;
(
   input  logic [SEC_W-1:0] bin,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   // Tens digit by threshold compare; ones is the remainder, which fits in the low nibble modulo 16.
   always_comb begin
      tens = '0;
      for (int i = 1; i <= 9; i++) begin
         if (bin >= SEC_W'(i * 10)) begin
            tens = BCD_W'(i);
         end
      end
      ones = bin[BCD_W-1:0] - BCD_W'(tens * BCD_W'(10));
   end

endmodule

// File: rtl/err_countdown.sv
// Error countdown controller: on an accepted start it latches the error code
// and counts a BCD seconds value down to zero, pulsing timeout on expiry.
// Optional feature: define ERR_CD_PAUSE_EN to let the pause input freeze the count.
module err_countdown
   import err_countdown_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int DEFAULT_SEC = 10
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ERR_W-1:0] error_in,
   input  logic             cancel,
   input  logic             pause,
   input  logic [SEC_W-1:0] cfg_seconds,
   output logic [ERR_W-1:0] error_code,
   output logic [BCD_W-1:0] countdown_tens,
   output logic [BCD_W-1:0] countdown_ones,
   output logic             active,
   output logic             timeout
);

   localparam int              PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

   // Out-of-range menu values fall back to the default length.
   function automatic logic [SEC_W-1:0] eff_seconds(input logic [SEC_W-1:0] cfg);
      if (cfg >= ERR_CD_MIN_SEC && cfg <= ERR_CD_MAX_SEC) begin
         return cfg;
      end
      return SEC_W'(DEFAULT_SEC);
   endfunction

   state_t           state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [BCD_W-1:0] tens_d, ones_d;
   logic [ERR_W-1:0] err_d;
   logic             tmo_d;
   logic [BCD_W-1:0] load_tens, load_ones;
   logic             start_ok;
   logic             hold;

   bin2bcd_99 u_bin2bcd (
      .bin  (eff_seconds(cfg_seconds)),
      .tens (load_tens),
      .ones (load_ones)
   );

   assign start_ok = start && (error_in != ERR_NONE);

`ifdef ERR_CD_PAUSE_EN
   assign hold = pause;
`else
   // Port kept for a uniform interface; the count never holds in this build.
   logic unused_pause;
   assign unused_pause = pause;
   assign hold         = 1'b0;
`endif

   // Next-state and next-output logic; cancel beats start, start beats the tick.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tens_d  = countdown_tens;
      ones_d  = countdown_ones;
      err_d   = error_code;
      tmo_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            tens_d  = '0;
            ones_d  = '0;
            err_d   = ERR_NONE;
            if (!cancel && start_ok) begin
               state_d = ST_RUN;
               err_d   = error_in;
               tens_d  = load_tens;
               ones_d  = load_ones;
            end
         end
         ST_RUN: begin
            if (cancel) begin
               state_d = ST_IDLE;
               presc_d = '0;
               tens_d  = '0;
               ones_d  = '0;
               err_d   = ERR_NONE;
            end else if (start_ok) begin
               presc_d = '0;
               err_d   = error_in;
               tens_d  = load_tens;
               ones_d  = load_ones;
            end else if (!hold) begin
               if (presc_q == PRE_LAST) begin
                  presc_d = '0;
                  if (countdown_tens == '0 && countdown_ones == BCD_W'(1)) begin
                     state_d = ST_IDLE;
                     tens_d  = '0;
                     ones_d  = '0;
                     err_d   = ERR_NONE;
                     tmo_d   = 1'b1;
                  end else if (countdown_ones == '0) begin
                     ones_d = BCD_W'(9);
                     tens_d = countdown_tens - BCD_W'(1);
                  end else begin
                     ones_d = countdown_ones - BCD_W'(1);
                  end
               end else begin
                  presc_d = presc_q + PRE_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         presc_q        <= '0;
         error_code     <= ERR_NONE;
         countdown_tens <= '0;
         countdown_ones <= '0;
         active         <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         error_code     <= err_d;
         countdown_tens <= tens_d;
         countdown_ones <= ones_d;
         active         <= (state_d == ST_RUN);
         timeout        <= tmo_d;
      end
   end

endmodule

// File: doc/err_countdown.md
ERR_COUNTDOWN -- requirements
Module: err_countdown

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clock cycles per countdown second.
REQ-002 SHALL have parameter DEFAULT_SEC, default 10, countdown length used when cfg_seconds is invalid.
REQ-003 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start  input  1  one-cycle request to begin an error countdown.
REQ-006 SHALL have error_in  input  4  error code from the compute path, sampled on start.
REQ-007 SHALL have cancel  input  1  one-cycle abort, asserted when the user re-enters valid operands.
REQ-008 SHALL have pause  input  1  level-sensitive hold, functional only under ERR_CD_PAUSE_EN.
REQ-009 SHALL have cfg_seconds  input  7  countdown length in binary seconds, from the settings menu.
REQ-010 SHALL have error_code  output  4  latched error; nonzero only while counting.
REQ-011 SHALL have countdown_tens  output  4  BCD tens digit, 0..9.
REQ-012 SHALL have countdown_ones  output  4  BCD ones digit, 0..9.
REQ-013 SHALL have active  output  1  high while in state RUN.
REQ-014 SHALL have timeout  output  1  one-cycle pulse when the countdown expires.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and RUN; all outputs registered.
REQ-016 SHALL treat cfg_seconds in 1..99 as valid; 0 or >99 SHALL load DEFAULT_SEC.
REQ-017 SHALL accept start only when error_in != 0; start with error_in == 0 SHALL be ignored in every state.
REQ-018 Accepted start, in IDLE or RUN, SHALL on the next edge: latch error_code=error_in; load BCD digits of the effective seconds; clear the prescaler; enter RUN.
REQ-019 A start in RUN SHALL restart with the new code and length; no timeout is generated.
REQ-020 Prescaler SHALL count 0..CLK_HZ-1 in RUN; the wrap cycle is the tick, giving the first decrement exactly CLK_HZ cycles after the load edge.
REQ-021 On a tick, the BCD value SHALL decrement: ones 0 -> 9 with tens-1, otherwise ones-1.
REQ-022 A tick while the value is 01 SHALL, on the next edge: set digits 00, error_code 0, timeout 1 for one cycle, and enter IDLE.
REQ-023 cancel in RUN SHALL, on the next edge: enter IDLE with error_code 0 and digits 00; timeout SHALL stay 0.
REQ-024 cancel SHALL take priority over start and tick in the same cycle; cancel in IDLE SHALL be a no-op.
REQ-025 In IDLE, digits SHALL hold 00, error_code 0, active 0, and the prescaler SHALL hold 0.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, prescaler 0, error_code 0, digits 00, active 0, timeout 0, including mid-countdown.
REQ-027 The first start SHALL be honoured on the first clock edge after rst_n deasserts.

Configuration
REQ-028 With ERR_CD_PAUSE_EN defined, pause high in RUN SHALL freeze the prescaler and digits; cancel and start SHALL still act.
REQ-029 Without ERR_CD_PAUSE_EN, the pause port SHALL exist but be ignored; no pause logic is synthesized.

Structure
REQ-030 The shared package SHALL hold the error-code constants (0 = none) and the BCD digit width.
REQ-031 The shared package SHALL hold the ERR_CD_MIN_SEC=1 and ERR_CD_MAX_SEC=99 bounds.
REQ-032 Binary-to-BCD conversion of 0..99 SHALL live in sub-module bin2bcd_99, which is combinational and instantiated once.

Verification (CLK_HZ=10 in simulation)
REQ-033 start, error_in=3, cfg=12 -> error_code=3, digits 1/2; at +10 cycles digits 1/1; after 120 cycles timeout pulses once, error_code=0, digits 00.
REQ-034 cfg=0 and cfg=120 -> loads 1/0 (DEFAULT_SEC); cfg=1 -> timeout exactly 10 cycles after load.
REQ-035 cfg=10 -> after 1 tick digits read 0/9, exercising the borrow path.
REQ-036 cancel and start asserted together mid-count -> IDLE, digits 00, no timeout; a start with error_in=0 -> no change.
REQ-037 Restart mid-count with error_in=5, cfg=20 -> digits 2/0, prescaler realigned; rst_n low mid-count -> all outputs zero immediately.
REQ-038 With ERR_CD_PAUSE_EN, pause held 25 cycles -> digits frozen and timeout delayed by 25 cycles; without the macro, pause has no effect.
